// File: rtl/decoder_pipe.sv
// decoder_pipe: per-item binary decoder (one-hot / thermometer / accumulate) feeding a DEPTH-entry output FIFO.
module decoder_pipe #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [WIDTH-1:0]      iData,
  input  logic [1:0]            iMode,
  input  logic                  iClear,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [2**WIDTH-1:0]   oData
);
  localparam int N  = 2**WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  acc_q, acc_d, acc_upd, onehot, low, high, word;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  assign oReady = (cnt_q < FULL) && !iRst;
  assign oValid = cnt_q != '0;
  assign oData  = mem_q[rd_q];
  always_comb begin
    onehot = '0;
    low    = '0;
    high   = '0;
    for (int k = 0; k < N; k++) begin
      onehot[k] = k == int'(iData);
      low[k]    = k <= int'(iData);
      high[k]   = k >= int'(iData);
    end
    acc_upd = (iClear ? '0 : acc_q) | onehot;
    word    = iMode == 2'b00 ? onehot : iMode == 2'b01 ? low : iMode == 2'b10 ? high : acc_upd;
    push    = iValid && oReady;
    pop     = oValid && iReady;
    acc_d   = push && iMode == 2'b11 ? acc_upd : acc_q;
    wr_d    = push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
    rd_d    = pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      acc_q <= acc_d;
      if (push) mem_q[wr_q] <= word;
    end
  end
endmodule
